l2_line_responder: RTL

- Responder end of the line-granularity L2 request interface driven by the I/D cache arbiter: accepts one 256-bit line read or write at a time on the `l2_*` port.
- Completes each request against physical memory as a 4-beat, 64-bit burst.
- Keeps a one-entry line buffer so a repeated read of the same line responds without a burst.
- Sits directly below the arbiter and above the pmem burst interface.

---
 rtl/l2r_pkg.sv | 20 ++
 rtl/l2r_line_buffer.sv | 47 ++++
 rtl/l2_line_responder.sv | 103 ++++++++++
 3 files changed

// File: rtl/l2r_pkg.sv
// Shared types and sizing for the L2 line responder: line/beat geometry and FSM states.
package l2r_pkg;

    localparam int S_OFFSET   = 5;
    localparam int S_LINE     = 8 * (2 ** S_OFFSET);
    localparam int S_BEAT     = 64;
    localparam int N_BEATS    = S_LINE / S_BEAT;
    localparam int BEAT_IDX_W = $clog2(N_BEATS);
    localparam int TAG_W      = 32 - S_OFFSET;

    localparam logic [BEAT_IDX_W-1:0] LAST_BEAT = BEAT_IDX_W'(N_BEATS - 1);

    typedef enum logic [1:0] {
        IDLE,
        RD_BURST,
        WR_BURST,
        RESPOND
    } l2r_state_t;

endpackage

// File: rtl/l2r_line_buffer.sv
// One-entry line buffer: valid bit, line tag and line data, filled beat-wise or whole-line.
module l2r_line_buffer
    import l2r_pkg::*;
(
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  beat_we,
    input  logic [BEAT_IDX_W-1:0] beat_idx,
    input  logic [S_BEAT-1:0]     beat_data,
    input  logic                  line_we,
    input  logic [S_LINE-1:0]     line_data,
    input  logic                  fill_done,
    input  logic [TAG_W-1:0]      fill_tag,
    input  logic [TAG_W-1:0]      lookup_tag,
    output logic                  hit,
    output logic [S_LINE-1:0]     line
);

    logic                               valid_q;
    logic [TAG_W-1:0]                   tag_q;
    logic [N_BEATS-1:0][S_BEAT-1:0]     line_q;

    // NOTE: sequential state uses non-blocking assignments only. The line itself is
    // cleared on reset as well, because l2_rdata is driven straight from it and must read 0.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q <= 1'b0;
            tag_q   <= '0;
            line_q  <= '0;
        end else begin
            if (beat_we) begin
                line_q[beat_idx] <= beat_data;
            end
            if (line_we) begin
                line_q <= line_data;
            end
            if (fill_done) begin
                valid_q <= 1'b1;
                tag_q   <= fill_tag;
            end
        end
    end

    assign hit  = valid_q && (tag_q == lookup_tag);
    assign line = line_q;

endmodule

// File: rtl/l2_line_responder.sv
// Line-granularity L2 responder: serves one 256-bit read/write as a 4-beat pmem burst,
// with a one-entry line buffer so repeated reads of the same line skip the burst.
module l2_line_responder
    import l2r_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic              l2_read,
    input  logic              l2_write,
    input  logic [31:0]       l2_address,
    input  logic [S_LINE-1:0] l2_wdata,
    input  logic              l2_stall,
    output logic              l2_resp,
    output logic [S_LINE-1:0] l2_rdata,
    output logic              l2_ready,
    output logic              pmem_read,
    output logic              pmem_write,
    output logic [31:0]       pmem_address,
    output logic [S_BEAT-1:0] pmem_wdata,
    input  logic [S_BEAT-1:0] pmem_rdata,
    input  logic              pmem_resp
);

    l2r_state_t                     state;
    logic [BEAT_IDX_W-1:0]          cnt;
    logic [TAG_W-1:0]               tag_q;
    logic [N_BEATS-1:0][S_BEAT-1:0] wdata_q;

    logic                  hit;
    logic                  last_beat;
    logic [TAG_W-1:0]      req_tag;
    logic                  unused_offset;

    assign req_tag       = l2_address[31:S_OFFSET];
    assign unused_offset = ^l2_address[S_OFFSET-1:0];
    assign last_beat     = pmem_resp && (cnt == LAST_BEAT);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            cnt     <= '0;
            tag_q   <= '0;
            wdata_q <= '0;
        end else begin
            case (state)
                IDLE: begin
                    cnt <= '0;
                    // A write wins when both strobes are up; the read is dropped.
                    if (l2_write) begin
                        tag_q   <= req_tag;
                        wdata_q <= l2_wdata;
                        state   <= WR_BURST;
                    end else if (l2_read) begin
                        if (hit) begin
                            state <= RESPOND;
                        end else begin
                            tag_q <= req_tag;
                            state <= RD_BURST;
                        end
                    end
                end
                RD_BURST, WR_BURST: begin
                    if (pmem_resp) begin
                        cnt <= cnt + BEAT_IDX_W'(1);
                        if (last_beat) begin
                            state <= RESPOND;
                        end
                    end
                end
                RESPOND: begin
                    if (!l2_stall) begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    l2r_line_buffer u_line_buffer (
        .clk        (clk),
        .rst_n      (rst_n),
        .beat_we    ((state == RD_BURST) && pmem_resp),
        .beat_idx   (cnt),
        .beat_data  (pmem_rdata),
        .line_we    ((state == WR_BURST) && last_beat),
        .line_data  (wdata_q),
        .fill_done  (((state == RD_BURST) || (state == WR_BURST)) && last_beat),
        .fill_tag   (tag_q),
        .lookup_tag (req_tag),
        .hit        (hit),
        .line       (l2_rdata)
    );

    // Everything toward pmem decodes from registered state, so reset drops strobes at once.
    assign pmem_read    = (state == RD_BURST);
    assign pmem_write   = (state == WR_BURST);
    assign pmem_address = {tag_q, {S_OFFSET{1'b0}}};
    assign pmem_wdata   = wdata_q[cnt];
    assign l2_resp      = (state == RESPOND);
    assign l2_ready     = (state == IDLE) || ((state == RESPOND) && !l2_stall);

endmodule
